// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns the PC, the instruction-memory handshake, opcode
// legality, HALT and the CPDR debug handshake, and drives current_state to the datapath.
module fetch_sequencer #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr0,
  output logic [3:0]          current_state,
  output logic [PC_WIDTH-1:0] pc,
  output logic                dbg_valid,
  input  logic                dbg_ack,
  output logic                halted,
  output logic                err_illegal,
  output logic [31:0]         instr_count
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    EXEC  = 4'd1,
    FETCH = 4'd2,
    HALT  = 4'd4
  } state_t;

  localparam logic [7:0] OP_CPDR = 8'hd3;
  localparam logic [7:0] OP_HALT = 8'hff;

  state_t              state, state_nx;
  logic [PC_WIDTH-1:0] pc_nx, addr_nx;
  logic                req_nx, dbg_nx, halted_nx, err_nx;
  logic [31:0]         instr_nx, count_nx;
  logic [7:0]          fetched_op;

  assign fetched_op    = imem_rdata[31:24];
  assign current_state = state;

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h02, 8'h14, 8'h15, 8'hd2, 8'hd3, 8'hff: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr0      <= '0;
      dbg_valid   <= 1'b0;
      halted      <= 1'b0;
      err_illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
      instr0      <= instr_nx;
      dbg_valid   <= dbg_nx;
      halted      <= halted_nx;
      err_illegal <= err_nx;
      instr_count <= count_nx;
    end
  end

  // dbg_valid doubles as the "current instruction is CPDR" marker while in EXEC.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    req_nx    = imem_req;
    addr_nx   = imem_addr;
    instr_nx  = instr0;
    dbg_nx    = dbg_valid;
    halted_nx = halted;
    err_nx    = err_illegal;
    count_nx  = instr_count;

    case (state)
      IDLE: begin
        if (start) begin
          pc_nx    = start_pc;
          req_nx   = 1'b1;
          addr_nx  = start_pc;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (imem_req && imem_ack) begin
          instr_nx = imem_rdata;
          req_nx   = 1'b0;
          pc_nx    = pc + PC_WIDTH'(1);
          if (fetched_op == OP_HALT) begin
            state_nx  = HALT;
            halted_nx = 1'b1;
          end else if (!is_legal(fetched_op)) begin
            state_nx  = HALT;
            halted_nx = 1'b1;
            err_nx    = 1'b1;
          end else begin
            state_nx = EXEC;
            dbg_nx   = (fetched_op == OP_CPDR);
          end
        end
      end
      EXEC: begin
        if (!dbg_valid || dbg_ack) begin
          dbg_nx   = 1'b0;
          count_nx = instr_count + 32'd1;
          req_nx   = 1'b1;
          addr_nx  = pc;
          state_nx = FETCH;
        end
      end
      HALT: begin
        if (start) begin
          err_nx    = 1'b0;
          halted_nx = 1'b0;
          pc_nx     = start_pc;
          req_nx    = 1'b1;
          addr_nx   = start_pc;
          state_nx  = FETCH;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
        dbg_nx   = 1'b0;
      end
    endcase
  end

endmodule
